// File: rtl/usb_bulk_pkg.sv
// rtl/usb_bulk_pkg.sv - shared types and parameter helpers for the bulk IN packet buffer
//
// Purpose: FSM state encoding for the IN transaction sequencer and the set of
// legal USB full-speed bulk max packet sizes.
// Ports: none (package).

package usb_bulk_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } bulk_state_e;

  localparam int MPS_LEGAL [4] = '{8, 16, 32, 64};

  function automatic bit mps_is_legal(input int mps);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (MPS_LEGAL[i] == mps) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bulk_pkt_ram.sv
// rtl/bulk_pkt_ram.sv - DEPTH x 8 register array, synchronous write, asynchronous read
//
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   write byte
//   raddr  in   read index
//   rdata  out  byte at raddr (combinational)

module bulk_pkt_ram #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bulk_in_pkt_buf.sv
// rtl/bulk_in_pkt_buf.sv - bulk IN endpoint buffer with ACK-gated release and packet replay
//
// Ports:
//   clk_i           in   clock
//   rst_i           in   asynchronous active-high reset
//   usb_reset_i     in   synchronous clear (same effect as rst_i)
//   app_in_data_i   in   application byte
//   app_in_valid_i  in   application byte valid
//   app_in_ready_o  out  buffer can accept a byte
//   in_req_i        in   high for the duration of an IN transaction
//   in_ready_i      in   SIE consumes in_data_o
//   in_data_ack_i   in   host ACK, qualified by out_ready_i
//   out_ready_i     in   strobe qualifying in_data_ack_i
//   in_data_o       out  byte at read pointer
//   in_valid_o      out  in_data_o belongs to the current packet
//   in_nak_o        out  nothing to send (no data, no ZLP pending)
//   in_level_o      out  bytes written but not yet acknowledged
//   in_empty_o      out  in_level_o == 0

module bulk_in_pkt_buf
  import usb_bulk_pkg::*;
#(
  parameter int DEPTH         = 64,
  parameter int MAXPACKETSIZE = 8,
  parameter bit ZLP_EN        = 1'b1,
  localparam int CW           = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          usb_reset_i,
  input  logic [7:0]    app_in_data_i,
  input  logic          app_in_valid_i,
  output logic          app_in_ready_o,
  input  logic          in_req_i,
  input  logic          in_ready_i,
  input  logic          in_data_ack_i,
  input  logic          out_ready_i,
  output logic [7:0]    in_data_o,
  output logic          in_valid_o,
  output logic          in_nak_o,
  output logic [CW-1:0] in_level_o,
  output logic          in_empty_o
);

  localparam int AW = CW - 1;
  localparam int PW = $clog2(MAXPACKETSIZE) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] MPS_C   = PW'(MAXPACKETSIZE);

  if (!mps_is_legal(MAXPACKETSIZE) || (DEPTH < 2 * MAXPACKETSIZE) ||
      ((DEPTH & (DEPTH - 1)) != 0)) begin : g_param_check
    $error("bulk_in_pkt_buf: illegal DEPTH/MAXPACKETSIZE combination");
  end

  // wr_ptr: next free slot; rd_ptr: next byte to send; cm_ptr: oldest unacked byte.
  // The extra MSB on each pointer distinguishes full from empty.
  logic [CW-1:0] wr_ptr, rd_ptr, cm_ptr;
  logic [CW-1:0] level;
  logic [PW-1:0] pkt_cnt;
  logic          zlp_pend;
  logic          in_req_q;
  bulk_state_e   state;

  logic wr_fire, start, ack, rd_fire;

  assign level          = wr_ptr - cm_ptr;
  assign app_in_ready_o = (level < DEPTH_C);
  assign wr_fire        = app_in_valid_i & app_in_ready_o;
  assign start          = in_req_i & ~in_req_q;
  assign ack            = in_data_ack_i & out_ready_i;

  assign in_valid_o = (state == ST_XFER) && (rd_ptr != wr_ptr) && (pkt_cnt < MPS_C);
  assign in_nak_o   = (state == ST_XFER) && (cm_ptr == wr_ptr) && !zlp_pend;
  assign rd_fire    = in_ready_i & in_valid_o;
  assign in_level_o = level;
  assign in_empty_o = (level == '0);

  bulk_pkt_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk_i),
    .we    (wr_fire),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (app_in_data_i),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (in_data_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cm_ptr   <= '0;
      pkt_cnt  <= '0;
      zlp_pend <= 1'b0;
      in_req_q <= 1'b0;
      state    <= ST_IDLE;
    end else if (usb_reset_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cm_ptr   <= '0;
      pkt_cnt  <= '0;
      zlp_pend <= 1'b0;
      in_req_q <= 1'b0;
      state    <= ST_IDLE;
    end else begin
      in_req_q <= in_req_i;
      if (wr_fire) wr_ptr <= wr_ptr + CW'(1);

      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_XFER;
            pkt_cnt <= '0;
          end
        end
        ST_XFER: begin
          // ACK outranks a simultaneous in_req_i fall. A zero-byte ACK leaves
          // cm_ptr where it is and clears zlp_pend, covering both the ZLP ACK
          // and the ACK of a NAKed transaction.
          if (ack) begin
            cm_ptr   <= rd_ptr;
            zlp_pend <= ZLP_EN && (pkt_cnt == MPS_C);
            state    <= ST_IDLE;
          end else if (!in_req_i) begin
            rd_ptr <= cm_ptr;
            state  <= ST_IDLE;
          end else if (rd_fire) begin
            rd_ptr  <= rd_ptr + CW'(1);
            pkt_cnt <= pkt_cnt + PW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bulk_in_pkt_buf.sv
// tb/tb_bulk_in_pkt_buf.sv - self-checking bench for bulk_in_pkt_buf against a queue model

module tb_bulk_in_pkt_buf;

  localparam int DEPTH = 64;
  localparam int MPS   = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_i, usb_reset_i;
  logic [7:0]    app_in_data_i;
  logic          app_in_valid_i, in_req_i, in_ready_i, in_data_ack_i, out_ready_i;
  logic          app_in_ready_o, in_valid_o, in_nak_o, in_empty_o;
  logic [7:0]    in_data_o;
  logic [CW-1:0] in_level_o;
  logic          rdy0, val0, nak0, emp0;
  logic [7:0]    dat0;
  logic [CW-1:0] lvl0;

  always #5 clk = ~clk;

  bulk_in_pkt_buf #(.DEPTH(DEPTH), .MAXPACKETSIZE(MPS), .ZLP_EN(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .usb_reset_i(usb_reset_i),
    .app_in_data_i(app_in_data_i), .app_in_valid_i(app_in_valid_i),
    .app_in_ready_o(app_in_ready_o), .in_req_i(in_req_i), .in_ready_i(in_ready_i),
    .in_data_ack_i(in_data_ack_i), .out_ready_i(out_ready_i), .in_data_o(in_data_o),
    .in_valid_o(in_valid_o), .in_nak_o(in_nak_o), .in_level_o(in_level_o),
    .in_empty_o(in_empty_o)
  );

  bulk_in_pkt_buf #(.DEPTH(DEPTH), .MAXPACKETSIZE(MPS), .ZLP_EN(1'b0)) u_dut_nozlp (
    .clk_i(clk), .rst_i(rst_i), .usb_reset_i(usb_reset_i),
    .app_in_data_i(app_in_data_i), .app_in_valid_i(app_in_valid_i),
    .app_in_ready_o(rdy0), .in_req_i(in_req_i), .in_ready_i(in_ready_i),
    .in_data_ack_i(in_data_ack_i), .out_ready_i(out_ready_i), .in_data_o(dat0),
    .in_valid_o(val0), .in_nak_o(nak0), .in_level_o(lvl0), .in_empty_o(emp0)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Model: every written-but-unacked byte in a queue, bytes sent this transaction,
  // whether a transaction is open, ZLP owed, and last sampled in_req_i.
  logic [7:0] mq [$];
  int         sent;
  bit         m_xfer, m_zlp, m_req_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic bit m_valid();
    return m_xfer && (sent < mq.size()) && (sent < MPS);
  endfunction

  function automatic bit m_nak();
    return m_xfer && (mq.size() == 0) && !m_zlp;
  endfunction

  task automatic m_reset();
    mq.delete();
    sent    = 0;
    m_xfer  = 1'b0;
    m_zlp   = 1'b0;
    m_req_q = 1'b0;
  endtask

  task automatic m_edge();
    bit wrf, start, ackq, rdf;
    int n;
    if (usb_reset_i) begin
      m_reset();
      return;
    end
    wrf   = app_in_valid_i && (mq.size() < DEPTH);
    start = !m_xfer && in_req_i && !m_req_q;
    ackq  = in_data_ack_i && out_ready_i;
    rdf   = in_ready_i && m_valid();
    if (m_xfer) begin
      if (ackq) begin
        m_zlp = (sent == MPS);
        n = sent;
        for (int i = 0; i < n; i++) void'(mq.pop_front());
        sent   = 0;
        m_xfer = 1'b0;
      end else if (!in_req_i) begin
        sent   = 0;
        m_xfer = 1'b0;
      end else if (rdf) begin
        sent++;
      end
    end else if (start) begin
      m_xfer = 1'b1;
      sent   = 0;
    end
    if (wrf) mq.push_back(app_in_data_i);
    m_req_q = in_req_i;
  endtask

  task automatic compare();
    check("ready", app_in_ready_o, mq.size() < DEPTH);
    check("level", in_level_o, mq.size());
    check("empty", in_empty_o, mq.size() == 0);
    check("valid", in_valid_o, m_valid());
    check("nak", in_nak_o, m_nak());
    if (m_valid()) check("data", in_data_o, mq[sent]);
  endtask

  task automatic tick();
    m_edge();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic clr_inputs();
    usb_reset_i = 0; app_in_data_i = 0; app_in_valid_i = 0;
    in_req_i = 0; in_ready_i = 0; in_data_ack_i = 0; out_ready_i = 0;
  endtask

  task automatic do_rst();
    clr_inputs();
    rst_i = 1'b1;
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    compare();
  endtask

  task automatic wr(input logic [7:0] b);
    app_in_valid_i = 1; app_in_data_i = b;
    tick();
    app_in_valid_i = 0;
  endtask

  task automatic req_rise();
    in_req_i = 1;
    tick();
  endtask

  task automatic pull();
    in_ready_i = 1;
    tick();
    in_ready_i = 0;
  endtask

  task automatic drop();
    in_req_i = 0;
    tick();
  endtask

  task automatic ack_txn();
    in_data_ack_i = 1; out_ready_i = 1;
    tick();
    in_data_ack_i = 0; out_ready_i = 0; in_req_i = 0;
    tick();
  endtask

  initial begin
    clr_inputs();
    rst_i = 1'b1;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    compare();

    // reset mid-stream
    wr(8'h01); wr(8'h02); wr(8'h03);
    do_rst();
    check("rst_level", in_level_o, 0);
    check("rst_ready", app_in_ready_o, 1);
    check("rst_valid", in_valid_o, 0);
    check("rst_nak", in_nak_o, 0);

    // short packet
    wr(8'h11); wr(8'h22); wr(8'h33);
    req_rise();
    check("short_b0", in_data_o, 8'h11); pull();
    check("short_b1", in_data_o, 8'h22); pull();
    check("short_b2", in_data_o, 8'h33); pull();
    check("short_valid_end", in_valid_o, 0);
    check("short_lvl3", in_level_o, 3);
    ack_txn();
    check("short_lvl0", in_level_o, 0);
    req_rise();
    check("short_nak", in_nak_o, 1);
    drop();

    // retransmit
    for (int i = 0; i < 8; i++) wr(8'(i));
    req_rise();
    for (int i = 0; i < 8; i++) begin check("rt_first", in_data_o, i); pull(); end
    drop();
    check("rt_level_kept", in_level_o, 8);
    req_rise();
    for (int i = 0; i < 8; i++) begin check("rt_replay", in_data_o, i); pull(); end
    ack_txn();
    check("rt_level0", in_level_o, 0);
    req_rise();
    check("rt_zlp_nak", in_nak_o, 0);
    ack_txn();

    // ZLP with ZLP_EN=1 vs ZLP_EN=0
    do_rst();
    for (int i = 0; i < 8; i++) wr(8'(8'h80 + i));
    req_rise();
    repeat (8) pull();
    ack_txn();
    req_rise();
    check("zlp_valid", in_valid_o, 0);
    check("zlp_nak", in_nak_o, 0);
    check("nozlp_nak", nak0, 1);
    ack_txn();
    req_rise();
    check("zlp_cleared_nak", in_nak_o, 1);
    drop();

    // full boundary and pointer wrap
    do_rst();
    for (int i = 0; i < 64; i++) wr(8'(i * 3 + 1));
    check("full_ready", app_in_ready_o, 0);
    check("full_level", in_level_o, 64);
    wr(8'hee);
    req_rise();
    repeat (8) pull();
    drop();
    check("full_rewind_ready", app_in_ready_o, 0);
    req_rise();
    repeat (8) pull();
    in_data_ack_i = 1; out_ready_i = 1;
    tick();
    check("full_ready_after_ack", app_in_ready_o, 1);
    in_data_ack_i = 0; out_ready_i = 0; in_req_i = 0;
    tick();
    for (int i = 0; i < 8; i++) wr(8'(8'hc0 + i));
    check("wrap_level", in_level_o, 64);
    repeat (8) begin
      req_rise();
      repeat (8) pull();
      ack_txn();
    end
    check("wrap_drained", in_level_o, 0);
    req_rise();
    ack_txn();

    // ACK and in_req fall together
    for (int i = 0; i < 3; i++) wr(8'(8'h50 + i));
    req_rise();
    repeat (3) pull();
    in_data_ack_i = 1; out_ready_i = 1; in_req_i = 0;
    tick();
    in_data_ack_i = 0; out_ready_i = 0;
    check("sim_level", in_level_o, 0);
    req_rise();
    check("sim_nak", in_nak_o, 1);
    drop();

    // usb_reset mid-transaction
    for (int i = 0; i < 5; i++) wr(8'(8'h60 + i));
    req_rise();
    repeat (2) pull();
    usb_reset_i = 1; in_req_i = 0;
    tick();
    usb_reset_i = 0;
    check("usbrst_level", in_level_o, 0);
    check("usbrst_empty", in_empty_o, 1);
    check("usbrst_valid", in_valid_o, 0);
    check("usbrst_nak", in_nak_o, 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      app_in_valid_i = ($urandom_range(0, 99) < 60);
      app_in_data_i  = 8'($urandom);
      if ($urandom_range(0, 99) < 8) in_req_i = ~in_req_i;
      in_ready_i     = 1'($urandom);
      out_ready_i    = ($urandom_range(0, 99) < 15);
      in_data_ack_i  = ($urandom_range(0, 99) < 50);
      usb_reset_i    = ($urandom_range(0, 999) < 3);
      tick();
    end
    clr_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
